// File: rtl/mc_ifetch_port_pkg.sv
// rtl/mc_ifetch_port_pkg.sv - shared types and FSM encoding for the instruction-fetch memory port
package mc_ifetch_port_pkg;

    localparam int MCIF_BYTE_W = 8;
    localparam logic [31:0] MCIF_BLANK_ADDR = 32'h0000_0000;
    localparam logic MCIF_TRUE  = 1'b1;
    localparam logic MCIF_FALSE = 1'b0;

    typedef enum logic [1:0] {
        MCIF_IDLE  = 2'd0,
        MCIF_ISSUE = 2'd1,
        MCIF_DRAIN = 2'd2,
        MCIF_DONE  = 2'd3
    } mcif_state_t;

endpackage

// File: rtl/mc_ifetch_port.sv
// rtl/mc_ifetch_port.sv - fetches four RAM bytes per PC and returns a little-endian instruction word
// Optional one-entry fetch reuse register: MC_IFETCH_REUSE_EN
module mc_ifetch_port
    import mc_ifetch_port_pkg::*;
#(
    parameter int INST_BYTES = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          if_to_mc_valid,
    input  logic [ADDR_W-1:0]             if_to_mc_PC,
    input  logic                          flush_in,
    input  logic                          mem_gnt,
    input  logic [MCIF_BYTE_W-1:0]        mem_din,
    output logic [ADDR_W-1:0]             mem_a,
    output logic                          mem_wr,
    output logic                          mc_to_if_busy,
    output logic                          mc_to_if_ready,
    output logic [MCIF_BYTE_W*INST_BYTES-1:0] mc_to_if_inst
);

    localparam int INST_W = MCIF_BYTE_W * INST_BYTES;
    localparam int LANE_W = MCIF_BYTE_W * (INST_BYTES - 1);
    localparam logic [1:0] K_LAST = 2'(INST_BYTES - 1);

    mcif_state_t         state;
    logic [ADDR_W-1:0]   pc;
    logic [1:0]          k;
    // pend: the address presented last cycle was granted, so mem_din now carries its byte
    logic                pend;
    logic [LANE_W-1:0]   lanes;

`ifdef MC_IFETCH_REUSE_EN
    logic                reuse_valid;
    logic [ADDR_W-1:0]   reuse_pc;
    logic [INST_W-1:0]   reuse_inst;
    logic                reuse_hit;

    assign reuse_hit = reuse_valid && (reuse_pc == if_to_mc_PC);
`endif

    assign mem_wr         = MCIF_FALSE;
    assign mc_to_if_ready = (state == MCIF_DONE) && !flush_in && rdy_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= MCIF_IDLE;
            pc            <= '0;
            k             <= '0;
            pend          <= MCIF_FALSE;
            lanes         <= '0;
            mem_a         <= ADDR_W'(MCIF_BLANK_ADDR);
            mc_to_if_busy <= MCIF_FALSE;
            mc_to_if_inst <= '0;
`ifdef MC_IFETCH_REUSE_EN
            reuse_valid   <= MCIF_FALSE;
            reuse_pc      <= '0;
            reuse_inst    <= '0;
`endif
        end else if (rdy_in) begin
            if (flush_in) begin
                // Abort: any byte still in flight is simply never captured.
                state         <= MCIF_IDLE;
                k             <= '0;
                pend          <= MCIF_FALSE;
                mc_to_if_busy <= MCIF_FALSE;
            end else begin
                case (state)
                    MCIF_IDLE: begin
                        if (if_to_mc_valid) begin
                            pc            <= if_to_mc_PC;
                            k             <= '0;
                            pend          <= MCIF_FALSE;
                            mc_to_if_busy <= MCIF_TRUE;
`ifdef MC_IFETCH_REUSE_EN
                            if (reuse_hit) begin
                                mc_to_if_inst <= reuse_inst;
                                state         <= MCIF_DONE;
                            end else begin
                                mem_a <= if_to_mc_PC;
                                state <= MCIF_ISSUE;
                            end
`else
                            mem_a <= if_to_mc_PC;
                            state <= MCIF_ISSUE;
`endif
                        end
                    end
                    MCIF_ISSUE: begin
                        if (pend) begin
                            lanes <= {mem_din, lanes[LANE_W-1:MCIF_BYTE_W]};
                        end
                        if (mem_gnt) begin
                            pend <= MCIF_TRUE;
                            if (k == K_LAST) begin
                                state <= MCIF_DRAIN;
                            end else begin
                                mem_a <= pc + ADDR_W'(k) + ADDR_W'(1);
                                k     <= k + 2'd1;
                            end
                        end else begin
                            // Address is held and re-presented once the grant returns.
                            pend <= MCIF_FALSE;
                        end
                    end
                    MCIF_DRAIN: begin
                        mc_to_if_inst <= {mem_din, lanes};
                        pend          <= MCIF_FALSE;
                        k             <= '0;
                        state         <= MCIF_DONE;
                    end
                    MCIF_DONE: begin
                        mc_to_if_busy <= MCIF_FALSE;
                        state         <= MCIF_IDLE;
`ifdef MC_IFETCH_REUSE_EN
                        reuse_valid   <= MCIF_TRUE;
                        reuse_pc      <= pc;
                        reuse_inst    <= mc_to_if_inst;
`endif
                    end
                    default: state <= MCIF_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc_ifetch_port.sv
// tb/tb_mc_ifetch_port.sv - scoreboard bench for mc_ifetch_port against a byte-array RAM model
module tb_mc_ifetch_port;

`ifdef MC_IFETCH_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        valid;
    logic [31:0] pc_in;
    logic        flush;
    logic        gnt;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy;
    logic        ready;
    logic [31:0] inst;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
        bit          hit;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] trail[$];
    logic        prev_busy = 1'b0;

    bit          rv = 1'b0;
    logic [31:0] rpc = 32'h0;

    mc_ifetch_port dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .if_to_mc_valid (valid),
        .if_to_mc_PC    (pc_in),
        .flush_in       (flush),
        .mem_gnt        (gnt),
        .mem_din        (mem_din),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mc_to_if_busy  (busy),
        .mc_to_if_ready (ready),
        .mc_to_if_inst  (inst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rb(input logic [31:0] a);
        case (a)
            32'h0000_1000: rb = 8'h13;
            32'h0000_1001: rb = 8'h05;
            32'h0000_1002: rb = 8'h00;
            32'h0000_1003: rb = 8'h00;
            default:       rb = (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5a;
        endcase
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] a);
        model_inst = {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)};
    endfunction

    // RAM answers one cycle after a granted address; ungranted cycles return foreign data.
    always @(posedge clk) begin
        if (rdy) mem_din <= gnt ? rb(mem_a) : 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            trail.delete();
        end else begin
            if (!busy) trail.delete();
            else if (!prev_busy || mem_a !== trail[$]) trail.push_back(mem_a);
            prev_busy = busy;
            if (ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no pulse", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("inst", inst, e.inst);
                    chk("ready_cycle", cyc, e.cyc);
                    chk("ready_busy", busy, 1);
                    chk("mem_wr", mem_wr, 0);
                    if (e.hit) begin
                        chk("hit_trail_len", trail.size(), 1);
                    end else begin
                        chk("trail_len", trail.size(), 4);
                        for (int i = 0; i < 4; i++)
                            if (i < trail.size()) chk("trail_addr", trail[i], e.pc + 32'(i));
                    end
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int ga, input int gl,
                         input int ra, input int rl, input int fl);
        bit hit;
        int base;
        int e0;
        bit done;
        hit   = REUSE && rv && (a == rpc);
        pc_in = a;
        valid = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        if (fl < 0) begin
            base = hit ? 0 : 5 + gl;
            if (rl > 0 && ra >= 1 && ra <= base) base += rl;
            sbq.push_back('{a, model_inst(a), e0 + base, hit});
            rv  = 1'b1;
            rpc = a;
        end
        done = 1'b0;
        for (int j = 0; j < 80 && !done; j++) begin
            gnt   = !(j >= ga && j < ga + gl);
            rdy   = !(j >= ra && j < ra + rl);
            flush = (j == fl);
            @(negedge clk);
            if (j == fl) begin
                @(posedge clk); #1;
                flush = 1'b0;
                valid = 1'b0;
                chk("flush_busy", busy, 0);
                done = 1'b1;
            end else if (ready) begin
                @(posedge clk); #1;
                valid = 1'b0;
                chk("idle_busy", busy, 0);
                chk("idle_ready", ready, 0);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        gnt = 1'b1;
        rdy = 1'b1;
        valid = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL fetch_timeout: pc %h got no completion expected completion within 80 cycles", a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] last_pc;
        int mode;
        rst = 1'b1; rdy = 1'b1; valid = 1'b0; pc_in = '0; flush = 1'b0; gnt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_inst", inst, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        fetch(32'h0000_1000, 0, 0, 0, 0, -1);
        fetch(32'h0000_1000, 2, 3, 0, 0, -1);
        fetch(32'h0000_2000, 0, 0, 0, 0, 2);
        fetch(32'h0000_3000, 0, 0, 0, 0, -1);
        fetch(32'hFFFF_FFFE, 0, 0, 0, 0, -1);
        fetch(32'h0000_4000, 0, 0, 2, 4, -1);
        fetch(32'h0000_4000, 0, 0, 0, 0, -1);
        fetch(32'h0000_5000, 0, 0, 0, 0, 5);
        fetch(32'h0000_5000, 0, 0, 0, 0, -1);

        pc_in = 32'h0000_6000;
        valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mem_a", mem_a, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_inst", inst, 0);
        rv  = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        fetch(32'h0000_6000, 0, 0, 0, 0, -1);
        fetch(32'h0000_6000, 0, 0, 0, 0, -1);

        last_pc = 32'h0000_6000;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = last_pc;
                2:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = $urandom();
            endcase
            mode = $urandom_range(0, 3);
            case (mode)
                0: fetch(a, 0, 0, 0, 0, -1);
                1: fetch(a, $urandom_range(1, 3), $urandom_range(1, 3), 0, 0, -1);
                2: fetch(a, 0, 0, $urandom_range(1, 5), $urandom_range(1, 4), -1);
                default: fetch(a, 0, 0, 0, 0, (REUSE && rv && a == rpc) ? 0 : $urandom_range(0, 5));
            endcase
            last_pc = a;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
